// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretch single-cycle strobes into fixed-width level pulses with a queued pending count (PULSE_STRETCHER_RETRIGGER_EN makes HIGH-phase pulses reload the hold timer)
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_M1 = CW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic level_q, level_d, ovf_q, ovf_d;
  logic launch, dec, retrig, queue_in, inc, full, cnt_zero;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
  assign retrig = state_q == HIGH && pulse_in;
`else
  assign retrig = 1'b0;
`endif
  always_comb begin
    cnt_zero = cnt_q == '0;
    full = &pend_q;
    launch = state_q == IDLE && (pulse_in || pend_q != '0);
    dec = launch && pend_q != '0;
    queue_in = pulse_in && !(launch && pend_q == '0) && !retrig;
    inc = queue_in && (!full || dec);
    pend_d = pend_q + PEND_W'(inc) - PEND_W'(dec);
    ovf_d = ovf_q || (queue_in && full && !dec);
    state_d = state_q == IDLE ? (launch ? HIGH : IDLE) :
              state_q == HIGH ? (cnt_zero && !retrig ? GAP : HIGH) :
              (cnt_zero ? IDLE : GAP);
    cnt_d = launch || retrig ? HOLD_M1 :
            state_q == HIGH && cnt_zero ? GAP_M1 :
            cnt_zero ? '0 : cnt_q - CW'(1);
    level_d = state_d == HIGH;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      level_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
    end
  assign level_out = level_q;
  assign pending = pend_q;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE || pend_q != '0;
endmodule
